pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Next-address and context sequencer directly upstream of the dual-context program counter.
- Each cycle, computes the next fetch address (`address`) and the active context (`proc_num`, 0 = OS, 1 = process) from:
  - the current PC, fed back from the PC's `outPC`;
  - branch/jump requests from decode;
  - syscall and OS-resume requests.
- Owns the process time-slice counter: forces preemption into an OS vector when the quantum expires.
- Tracks the process resume point and the switch cause for the OS.

Parameters:
- ADDR_W, 10, width of all addresses.
- QUANTUM_W, 8, width of time-slice counter.
- PREEMPT_VECTOR, 10'd1, OS entry address on quantum expiry.
- SYSCALL_VECTOR, 10'd2, OS entry address on syscall.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- hlt  in  1  freeze: no state change, address = cur_pc
- cur_pc  in  ADDR_W  current PC (PC block `outPC`)
- branch_taken  in  1  conditional branch resolved taken
- branch_target  in  ADDR_W  branch destination
- jump  in  1  unconditional jump
- jump_target  in  ADDR_W  jump destination
- syscall  in  1  process requests OS service (ignored in OS context)
- os_resume  in  1  OS returns to process (ignored in process context)
- quantum  in  QUANTUM_W  time-slice length, sampled on accepted os_resume
- address  out  ADDR_W  next PC, combinational from state and inputs
- proc_num  out  1  registered active context, drives PC `proc_num`
- bubble  out  1  high in ENTER_OS cycle; downstream discards the fetched word
- saved_pc  out  ADDR_W  process resume address captured at last switch to OS
- switch_cause  out  2  00 none, 01 syscall, 10 quantum expiry
- quantum_left  out  QUANTUM_W  remaining process cycles

Behaviour:
- Reset (synchronous, active-high):
  - state = RUN_OS;
  - proc_num = 0, bubble = 0;
  - saved_pc = 0, switch_cause = 00, quantum_left = 0.
  - Reset overrides hlt and all requests.
  - Reset mid-ENTER_OS or mid-RUN_PROC aborts to RUN_OS.
- Normal next address:
  - nxt = jump ? jump_target : (branch_taken ? branch_target : cur_pc+1).
  - jump has priority over branch_taken.
  - cur_pc+1 wraps modulo 2^ADDR_W (10'h3FF -> 10'h000).
- hlt = 1 (any state, reset low):
  - address = cur_pc;
  - all registers hold, including quantum_left.
- States: RUN_OS (proc_num 0), RUN_PROC (proc_num 1), ENTER_OS (proc_num 0, bubble 1).
- RUN_OS:
  - address = nxt; syscall ignored.
  - os_resume: address = nxt (OS PC skips the resume instruction), quantum_left <= quantum, proc_num <= 1, state -> RUN_PROC.
  - The process PC register already holds its resume point, so the first process fetch is from saved_pc.
- RUN_PROC:
  - address = nxt; os_resume ignored.
  - Each cycle, if quantum_left != 0, quantum_left decrements by 1.
  - quantum_left == 0 on entry (quantum = 0) means no preemption.
  - Preemption fires when quantum_left == 1 at the edge (the last allowed cycle executes).
  - Switch trigger = syscall OR preemption. On trigger:
    - address = nxt, written into the process PC;
    - saved_pc <= nxt;
    - switch_cause <= 01 if syscall (syscall wins over simultaneous expiry), else 10;
    - quantum_left <= 0; proc_num <= 0; state -> ENTER_OS.
- ENTER_OS (exactly one cycle unless hlt):
  - address = SYSCALL_VECTOR if switch_cause == 01, else PREEMPT_VECTOR; this address is written into the OS PC.
  - bubble = 1; branch/jump/syscall/os_resume ignored.
  - state -> RUN_OS.
- switch_cause and saved_pc hold until the next switch or reset; os_resume does not clear them.
- Latency:
  - address is same-cycle combinational.
  - proc_num changes one edge after the trigger.
  - OS vector is fetched two edges after the trigger.

Test Plan:
- Reset then 3 cycles, cur_pc fed back from a model PC starting at 0 -> address 1,2,3; proc_num 0; bubble 0; quantum_left 0.
- Wrap and jump priority:
  - cur_pc = 10'h3FF, no branch -> address 10'h000.
  - cur_pc = 5, jump = 1 (jump_target 40) with branch_taken = 1 (branch_target 20) -> address 40.
- Resume and preemption:
  - In RUN_OS, os_resume with quantum = 3 -> proc_num 1 next cycle, quantum_left 3,2,1.
  - At quantum_left 1 with cur_pc = 12: address 13, then ENTER_OS with address 10'd1, bubble 1, saved_pc 13, switch_cause 10, then RUN_OS.
- Syscall with simultaneous expiry:
  - quantum_left = 1, syscall = 1, cur_pc = 7 -> saved_pc 8, switch_cause 01.
  - ENTER_OS address 10'd2.
- hlt:
  - hlt held 4 cycles in RUN_PROC with quantum_left 5 -> quantum_left stays 5, address = cur_pc, state unchanged.
  - hlt in ENTER_OS -> bubble stays 1, no transition.
- Reset and ignored requests:
  - reset asserted during ENTER_OS -> next cycle RUN_OS, proc_num 0, switch_cause 00, saved_pc 0.
  - syscall in RUN_OS and os_resume in RUN_PROC -> ignored; quantum = 0 resume -> never preempted in 300 cycles.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-fetch-address and OS/process context sequencer with time-slice preemption.
module pc_sequencer #(
  parameter int ADDR_W = 10,
  parameter int QUANTUM_W = 8,
  parameter logic [ADDR_W-1:0] PREEMPT_VECTOR = 10'd1,
  parameter logic [ADDR_W-1:0] SYSCALL_VECTOR = 10'd2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hlt,
  input  logic [ADDR_W-1:0]    cur_pc,
  input  logic                 branch_taken,
  input  logic [ADDR_W-1:0]    branch_target,
  input  logic                 jump,
  input  logic [ADDR_W-1:0]    jump_target,
  input  logic                 syscall,
  input  logic                 os_resume,
  input  logic [QUANTUM_W-1:0] quantum,
  output logic [ADDR_W-1:0]    address,
  output logic                 proc_num,
  output logic                 bubble,
  output logic [ADDR_W-1:0]    saved_pc,
  output logic [1:0]           switch_cause,
  output logic [QUANTUM_W-1:0] quantum_left
);
  typedef enum logic [1:0] {RUN_OS, RUN_PROC, ENTER_OS} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] nxt, saved_pc_nxt;
  logic [1:0] cause_nxt;
  logic [QUANTUM_W-1:0] ql_nxt;
  logic in_proc, trigger, sw, resume;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN_OS;
      saved_pc <= '0;
      switch_cause <= 2'b00;
      quantum_left <= '0;
    end else begin
      state <= state_nxt;
      saved_pc <= saved_pc_nxt;
      switch_cause <= cause_nxt;
      quantum_left <= ql_nxt;
    end
  end
  // Preemption fires on the last allowed cycle, so quantum_left==1 at the edge.
  always_comb begin
    in_proc = state == RUN_PROC;
    trigger = syscall || quantum_left == QUANTUM_W'(1);
    state_nxt = hlt ? state :
                state == RUN_OS ? (os_resume ? RUN_PROC : RUN_OS) :
                in_proc ? (trigger ? ENTER_OS : RUN_PROC) : RUN_OS;
  end
  always_comb begin
    nxt = jump ? jump_target : branch_taken ? branch_target : cur_pc + 1'b1;
    sw = !hlt && in_proc && trigger;
    resume = !hlt && state == RUN_OS && os_resume;
    saved_pc_nxt = sw ? nxt : saved_pc;
    cause_nxt = sw ? (syscall ? 2'b01 : 2'b10) : switch_cause;
    ql_nxt = resume ? quantum :
             sw ? '0 :
             (!hlt && in_proc && quantum_left != '0) ? quantum_left - 1'b1 : quantum_left;
    address = hlt ? cur_pc :
              state == ENTER_OS ? (switch_cause == 2'b01 ? SYSCALL_VECTOR : PREEMPT_VECTOR) : nxt;
    proc_num = in_proc;
    bubble = state == ENTER_OS;
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer.
module tb_pc_sequencer;
  logic clk = 0, reset = 1, hlt = 0, branch_taken = 0, jump = 0, syscall = 0, os_resume = 0;
  logic [9:0] cur_pc = 0, branch_target = 0, jump_target = 0;
  logic [7:0] quantum = 0;
  logic [9:0] address, saved_pc;
  logic proc_num, bubble;
  logic [1:0] switch_cause;
  logic [7:0] quantum_left;
  int checks = 0, errors = 0;
  typedef struct {
    string name;
    logic [9:0] addr;
    logic pn;
    logic bub;
    logic [9:0] spc;
    logic [1:0] cause;
    logic [7:0] ql;
  } exp_t;
  exp_t q[$];
  pc_sequencer dut (
    .clk(clk), .reset(reset), .hlt(hlt), .cur_pc(cur_pc),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .syscall(syscall),
    .os_resume(os_resume), .quantum(quantum), .address(address),
    .proc_num(proc_num), .bubble(bubble), .saved_pc(saved_pc),
    .switch_cause(switch_cause), .quantum_left(quantum_left)
  );
  always #5 clk = ~clk;
  task automatic cmp(string n, string f, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", n, f, act, req);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.name, "address", int'(address), int'(e.addr));
      cmp(e.name, "proc_num", int'(proc_num), int'(e.pn));
      cmp(e.name, "bubble", int'(bubble), int'(e.bub));
      cmp(e.name, "saved_pc", int'(saved_pc), int'(e.spc));
      cmp(e.name, "switch_cause", int'(switch_cause), int'(e.cause));
      cmp(e.name, "quantum_left", int'(quantum_left), int'(e.ql));
    end
  end
  task automatic step(string n, logic [9:0] a, logic pn, logic bub, logic [9:0] spc, logic [1:0] c, logic [7:0] ql);
    exp_t e;
    e.name = n; e.addr = a; e.pn = pn; e.bub = bub; e.spc = spc; e.cause = c; e.ql = ql;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    hlt = 0; branch_taken = 0; jump = 0; syscall = 0; os_resume = 0; reset = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 1; hlt = 1; syscall = 1;
    @(posedge clk); #1;
    idle();
    for (int i = 0; i < 3; i++) begin
      cur_pc = 10'(i);
      step("reset_run", 10'(i + 1), 0, 0, 0, 0, 0);
    end
    cur_pc = 10'h3FF;
    step("wrap", 10'h000, 0, 0, 0, 0, 0);
    cur_pc = 5; jump = 1; jump_target = 40; branch_taken = 1; branch_target = 20; syscall = 1;
    step("jump_prio", 40, 0, 0, 0, 0, 0);
    idle(); cur_pc = 10; os_resume = 1; quantum = 3;
    step("resume3", 11, 0, 0, 0, 0, 0);
    cur_pc = 10;
    step("proc_q3", 11, 1, 0, 0, 0, 3);
    os_resume = 0; cur_pc = 11;
    step("proc_q2", 12, 1, 0, 0, 0, 2);
    cur_pc = 12;
    step("proc_q1", 13, 1, 0, 0, 0, 1);
    jump = 1; jump_target = 99;
    step("enter_preempt", 1, 0, 1, 13, 2'b10, 0);
    idle(); cur_pc = 1;
    step("os_after_preempt", 2, 0, 0, 13, 2'b10, 0);
    cur_pc = 2; os_resume = 1; quantum = 2;
    step("resume2", 3, 0, 0, 13, 2'b10, 0);
    idle(); cur_pc = 13;
    step("proc2_q2", 14, 1, 0, 13, 2'b10, 2);
    cur_pc = 7; syscall = 1;
    step("sys_expiry", 8, 1, 0, 13, 2'b10, 1);
    idle(); cur_pc = 8;
    step("enter_sys", 2, 0, 1, 8, 2'b01, 0);
    cur_pc = 2;
    step("os_after_sys", 3, 0, 0, 8, 2'b01, 0);
    cur_pc = 3; os_resume = 1; quantum = 6;
    step("resume6", 4, 0, 0, 8, 2'b01, 0);
    idle(); cur_pc = 8;
    step("proc6_q6", 9, 1, 0, 8, 2'b01, 6);
    for (int i = 0; i < 4; i++) begin
      cur_pc = 9; hlt = 1; syscall = (i == 2);
      step("hlt_proc", 9, 1, 0, 8, 2'b01, 5);
    end
    idle(); cur_pc = 9;
    step("hlt_release", 10, 1, 0, 8, 2'b01, 5);
    cur_pc = 10; syscall = 1;
    step("sys_q4", 11, 1, 0, 8, 2'b01, 4);
    idle(); cur_pc = 11;
    for (int i = 0; i < 2; i++) begin
      hlt = 1;
      step("hlt_enter", 11, 0, 1, 11, 2'b01, 0);
    end
    hlt = 0; reset = 1;
    step("reset_enter", 2, 0, 1, 11, 2'b01, 0);
    idle(); cur_pc = 2;
    step("after_reset", 3, 0, 0, 0, 0, 0);
    cur_pc = 3; os_resume = 1; quantum = 0;
    step("resume0", 4, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      idle(); cur_pc = 10'(100 + i); os_resume = (i % 7 == 0); quantum = 5;
      step("no_preempt", 10'(101 + i), 1, 0, 0, 0, 0);
    end
    idle();
    @(negedge clk);
    cmp("drain", "queue_size", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
